// File: rtl/t05_hist_builder.sv
// t05_hist_builder
// Builds the 256-bin character histogram held in the SRAM behind
// t05_sram_interface. After start it clears every bin. It then accepts one
// byte per handshake and does a read-modify-write of bin[byte]. On end of
// file it reports the number of bytes accepted and pulses done.
//
// Optional build macro: HIST_SATURATE_EN
//   defined   - bins and total_chars saturate at 2^CNT_W-1. A bin that is
//               already saturated is not rewritten.
//   undefined - bins and total_chars wrap modulo 2^CNT_W.
//
// Note: the reset input is named rst but is asynchronous and active-low.

module t05_hist_builder #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned BINS  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              in_char,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    eof,
    output logic [CNT_W-1:0]        histogram,
    output logic [$clog2(BINS)-1:0] histgram_addr,
    output logic                    hist_r_wr,
    output logic                    hist_req,
    input  logic                    busy_i,
    input  logic [CNT_W-1:0]        old_char,
    output logic [CNT_W-1:0]        total_chars,
    output logic                    done
);

    localparam int unsigned      ADDR_W   = $clog2(BINS);
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [3:0] {
        IDLE,
        CLR_REQ,
        CLR_WAIT,
        ACCEPT,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              pend_eof;   // eof arrived together with the last byte

    logic [CNT_W-1:0]  bin_next;
    logic [CNT_W-1:0]  total_next;
    logic              skip_write;

    // Incremented bin/total values and the saturated-bin write bypass
    always_comb begin
        // NOTE: every output of a combinational block is given a default first
        // so that no path leaves it unassigned, which would infer a latch.
        bin_next   = old_char + CNT_W'(1);
        total_next = total_chars + CNT_W'(1);
        skip_write = 1'b0;
`ifdef HIST_SATURATE_EN
        if (old_char == CNT_MAX) begin
            bin_next   = CNT_MAX;
            skip_write = 1'b1;
        end
        if (total_chars == CNT_MAX) begin
            total_next = CNT_MAX;
        end
`endif
    end

    // Control FSM; every SRAM-side and handshake output is registered here
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so that every register
        // samples pre-edge values, independent of statement order.
        if (!rst) begin
            state         <= IDLE;
            clr_addr      <= '0;
            pend_eof      <= 1'b0;
            in_ready      <= 1'b0;
            histogram     <= '0;
            histgram_addr <= '0;
            hist_r_wr     <= 1'b0;
            hist_req      <= 1'b0;
            total_chars   <= '0;
            done          <= 1'b0;
        end else begin
            case (state)
                // Wait for start; total_chars keeps its last value meanwhile
                IDLE: begin
                    if (start) begin
                        state         <= CLR_REQ;
                        clr_addr      <= '0;
                        total_chars   <= '0;
                        pend_eof      <= 1'b0;
                        hist_req      <= 1'b1;
                        hist_r_wr     <= 1'b1;
                        histgram_addr <= '0;
                        histogram     <= '0;
                    end
                end

                // Write 0 to bin clr_addr; hold the request until acknowledged
                CLR_REQ: begin
                    if (busy_i) begin
                        state    <= CLR_WAIT;
                        hist_req <= 1'b0;
                    end
                end

                // The clear address stops at the last bin and never wraps
                CLR_WAIT: begin
                    if (!busy_i) begin
                        if (clr_addr == LAST_BIN) begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end else begin
                            state         <= CLR_REQ;
                            clr_addr      <= clr_addr + ADDR_W'(1);
                            histgram_addr <= clr_addr + ADDR_W'(1);
                            hist_req      <= 1'b1;
                        end
                    end
                end

                // A byte has priority over eof; eof given with it is deferred
                ACCEPT: begin
                    if (in_valid) begin
                        state         <= RD_REQ;
                        in_ready      <= 1'b0;
                        total_chars   <= total_next;
                        pend_eof      <= eof;
                        histgram_addr <= ADDR_W'(in_char);
                        hist_r_wr     <= 1'b0;
                        hist_req      <= 1'b1;
                    end else if (eof) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end

                RD_REQ: begin
                    if (busy_i) begin
                        state    <= RD_WAIT;
                        hist_req <= 1'b0;
                    end
                end

                // Read data is valid once busy_i drops
                RD_WAIT: begin
                    if (!busy_i) begin
                        if (skip_write) begin
                            if (pend_eof) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state    <= ACCEPT;
                                in_ready <= 1'b1;
                            end
                        end else begin
                            state     <= WR_REQ;
                            histogram <= bin_next;
                            hist_r_wr <= 1'b1;
                            hist_req  <= 1'b1;
                        end
                    end
                end

                WR_REQ: begin
                    if (busy_i) begin
                        state    <= WR_WAIT;
                        hist_req <= 1'b0;
                    end
                end

                // The read-modify-write finishes before the next byte is taken
                WR_WAIT: begin
                    if (!busy_i) begin
                        if (pend_eof) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end

                // done is high for exactly the one cycle spent in this state
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    pend_eof <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    hist_req <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
